// File: rtl/uart_image_pkg.sv
// rtl/uart_image_pkg.sv - shared state encoding and default widths for the UART image controller
package uart_image_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LOAD       = 3'd1;
  localparam logic [2:0] ST_DUMP_FETCH = 3'd2;
  localparam logic [2:0] ST_DUMP_WAIT  = 3'd3;
  localparam logic [2:0] ST_DUMP_SEND  = 3'd4;

endpackage

// File: rtl/uart_image_cnt.sv
// rtl/uart_image_cnt.sv - image byte counter with clear, saturating increment and last-byte flag
module uart_image_cnt #(
  parameter int ADDR_W = 16,
  parameter int LAST   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] addr_next_o,
  output logic              last_o
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_plus1;

  assign cnt_plus1   = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
  assign addr_o      = cnt_q[ADDR_W-1:0];
  assign addr_next_o = cnt_plus1[ADDR_W-1:0];
  assign last_o      = (cnt_q == LAST_C);

  // Increment stops at the last byte so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_plus1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_image_ctrl.sv
// rtl/uart_image_ctrl.sv - UART image load/dump controller around a single-port RAM
module uart_image_ctrl
  import uart_image_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int IMG_BYTES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic              abort,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_byte,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              tx_done,
  input  logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              load_done,
  output logic              dump_done,
  output logic              busy,
  output logic              rx_unexpected
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic              tx_start_q, tx_start_d;
  logic              load_done_q, load_done_d;
  logic              dump_done_q, dump_done_d;
  logic              rx_unexp_q, rx_unexp_d;

  logic              cnt_clr, cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt_addr, cnt_addr_next;

  uart_image_cnt #(
    .ADDR_W (ADDR_W),
    .LAST   (IMG_BYTES - 1)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (cnt_clr),
    .inc_i       (cnt_inc),
    .addr_o      (cnt_addr),
    .addr_next_o (cnt_addr_next),
    .last_o      (cnt_last)
  );

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    tx_byte_d   = tx_byte_q;
    tx_start_d  = 1'b0;
    load_done_d = 1'b0;
    dump_done_d = 1'b0;
    rx_unexp_d  = rx_unexp_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ram_addr_d = ext_addr;
          if (load_start) begin
            state_d    = ST_LOAD;
            cnt_clr    = 1'b1;
            rx_unexp_d = 1'b0;
          end else if (dump_start) begin
            state_d    = ST_DUMP_FETCH;
            cnt_clr    = 1'b1;
            ram_addr_d = '0;
          end
        end
        ST_LOAD: begin
          if (rx_valid) begin
            ram_we_d    = 1'b1;
            ram_addr_d  = cnt_addr;
            ram_wdata_d = rx_byte;
            if (cnt_last) begin
              load_done_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        // The address is already on the RAM while here; data arrives in DUMP_WAIT.
        ST_DUMP_FETCH: begin
          ram_addr_d = cnt_addr;
          state_d    = ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          tx_byte_d  = ram_rdata;
          tx_start_d = 1'b1;
          state_d    = ST_DUMP_SEND;
        end
        ST_DUMP_SEND: begin
          if (tx_done) begin
            if (cnt_last) begin
              dump_done_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              cnt_inc    = 1'b1;
              ram_addr_d = cnt_addr_next;
              state_d    = ST_DUMP_FETCH;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Set after the load_start clear so a stray byte in that same cycle is still flagged.
    if (rx_valid && (state_q != ST_LOAD)) begin
      rx_unexp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      tx_byte_q   <= '0;
      tx_start_q  <= 1'b0;
      load_done_q <= 1'b0;
      dump_done_q <= 1'b0;
      rx_unexp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      tx_byte_q   <= tx_byte_d;
      tx_start_q  <= tx_start_d;
      load_done_q <= load_done_d;
      dump_done_q <= dump_done_d;
      rx_unexp_q  <= rx_unexp_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign tx_byte       = tx_byte_q;
  assign tx_start      = tx_start_q;
  assign load_done     = load_done_q;
  assign dump_done     = dump_done_q;
  assign rx_unexpected = rx_unexp_q;
  assign busy          = (state_q != ST_IDLE);
  assign ext_rdata     = ram_rdata;

endmodule

// File: tb/tb_uart_image_ctrl.sv
// tb/tb_uart_image_ctrl.sv - self-checking bench for uart_image_ctrl with a RAM and UART tx model
module tb_uart_image_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0, dump_start = 1'b0, abort = 1'b0, rx_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic       u1_en = 1'b1;
  logic [7:0] rx_byte = 8'h00, ext_addr = 8'h00;

  logic       tx_start, ram_we, load_done, dump_done, busy, rx_unexpected;
  logic [7:0] tx_byte, ext_rdata, ram_addr, ram_wdata, ram_rdata;
  logic       tx_start1, ram_we1, load_done1, dump_done1, busy1, rx_unexpected1;
  logic [7:0] tx_byte1, ext_rdata1, ram_addr1, ram_wdata1, ram_rdata1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] ref_mem [4];
  logic [7:0] pat [4];
  logic [7:0] tx_log [$];

  int total = 0, bad = 0;
  int n_tx = 0, n_we = 0, n_ld = 0, n_dd = 0;
  int n1_tx = 0, n1_we = 0, n1_ld = 0, n1_dd = 0;
  int tx_cd = 0, tx_lat = 10;
  logic [7:0] w1_addr = 8'h00, w1_data = 8'h00, t1_byte = 8'h00;

  always #5 clk = ~clk;

  uart_image_ctrl #(.DATA_W(8), .ADDR_W(8), .IMG_BYTES(4)) u0 (
    .clk(clk), .rst(rst), .load_start(load_start), .dump_start(dump_start), .abort(abort),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_done(tx_done), .ext_addr(ext_addr), .ext_rdata(ext_rdata), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata), .load_done(load_done),
    .dump_done(dump_done), .busy(busy), .rx_unexpected(rx_unexpected));

  uart_image_ctrl #(.DATA_W(8), .ADDR_W(8), .IMG_BYTES(1)) u1 (
    .clk(clk), .rst(rst), .load_start(load_start & u1_en), .dump_start(dump_start & u1_en),
    .abort(abort), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_start(tx_start1),
    .tx_byte(tx_byte1), .tx_done(tx_done), .ext_addr(ext_addr), .ext_rdata(ext_rdata1),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_rdata(ram_rdata1),
    .load_done(load_done1), .dump_done(dump_done1), .busy(busy1),
    .rx_unexpected(rx_unexpected1));

  always @(posedge clk) begin
    if (ram_we) mem0[ram_addr] <= ram_wdata;
    ram_rdata <= mem0[ram_addr];
    if (ram_we1) mem1[ram_addr1] <= ram_wdata1;
    ram_rdata1 <= mem1[ram_addr1];
  end

  // Event monitor plus UART transmitter model answering tx_start after tx_lat cycles.
  always @(negedge clk) begin
    if (tx_start) begin n_tx++; tx_log.push_back(tx_byte); end
    if (tx_start1) begin n1_tx++; t1_byte = tx_byte1; end
    if (ram_we) n_we++;
    if (ram_we1) begin n1_we++; w1_addr = ram_addr1; w1_data = ram_wdata1; end
    if (load_done) n_ld++;
    if (dump_done) n_dd++;
    if (load_done1) n1_ld++;
    if (dump_done1) n1_dd++;
    tx_done = 1'b0;
    if (rst) tx_cd = 0;
    else if (tx_cd > 0) begin
      tx_cd--;
      if (tx_cd == 0) tx_done = 1'b1;
    end
    if (tx_start) tx_cd = tx_lat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if ({ram_we, tx_start, load_done, dump_done, busy, rx_unexpected} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000", {ram_we, tx_start, load_done, dump_done, busy, rx_unexpected});
    end
    total++;
    if ({tx_byte, ram_wdata, ram_addr} !== 24'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 000000", {tx_byte, ram_wdata, ram_addr});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic load_image(input bit both, input int gap_max);
    int we0, ld0, tx0, we1, ld1;
    we0 = n_we; ld0 = n_ld; tx0 = n_tx; we1 = n1_we; ld1 = n1_ld;
    load_start = 1'b1; dump_start = both; tick(); load_start = 1'b0; dump_start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL load_enter: busy=%b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      dump_start = both && (i == 1);
      rx_valid = 1'b1; rx_byte = pat[i]; tick(); rx_valid = 1'b0; dump_start = 1'b0;
      ref_mem[i] = pat[i];
      total++;
      if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 8'(i), pat[i]}) begin
        bad++;
        $display("FAIL load_write%0d: we/addr/data=%b/%h/%h want 1/%h/%h", i, ram_we, ram_addr, ram_wdata, 8'(i), pat[i]);
      end
      total++;
      if (load_done !== (i == 3)) begin
        bad++; $display("FAIL load_done_at%0d: got %b want %b", i, load_done, (i == 3));
      end
    end
    tick();
    total++;
    if ({busy, load_done, ram_we} !== 3'b000) begin
      bad++; $display("FAIL load_exit: busy/done/we=%b want 000", {busy, load_done, ram_we});
    end
    total++;
    if (n_ld - ld0 !== 1 || n_we - we0 !== 4 || n_tx - tx0 !== 0) begin
      bad++;
      $display("FAIL load_counts: done=%0d writes=%0d tx=%0d want 1 4 0", n_ld - ld0, n_we - we0, n_tx - tx0);
    end
    if (!both) begin
      total++;
      if (n1_we - we1 !== 1 || n1_ld - ld1 !== 1 || w1_addr !== 8'h00 || w1_data !== pat[0]) begin
        bad++;
        $display("FAIL single_load: writes=%0d done=%0d addr=%h data=%h want 1 1 00 %h", n1_we - we1, n1_ld - ld1, w1_addr, w1_data, pat[0]);
      end
    end
  endtask

  task automatic dump_image(input int lat);
    int tx0, dd0, tx1, dd1, base, c;
    logic [7:0] got;
    tx0 = n_tx; dd0 = n_dd; tx1 = n1_tx; dd1 = n1_dd; base = tx_log.size();
    tx_lat = lat;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL dump_enter: busy=%b want 1", busy); end
    c = 0;
    while (n_dd == dd0 && c < 4 * (lat + 10) + 50) begin tick(); c++; end
    repeat (3) tick();
    total++;
    if (n_dd - dd0 !== 1 || n_tx - tx0 !== 4) begin
      bad++; $display("FAIL dump_counts: done=%0d tx_start=%0d want 1 4", n_dd - dd0, n_tx - tx0);
    end
    total++;
    if ({busy, dump_done} !== 2'b00) begin
      bad++; $display("FAIL dump_exit: busy/done=%b want 00", {busy, dump_done});
    end
    for (int i = 0; i < 4; i++) begin
      got = (base + i < tx_log.size()) ? tx_log[base + i] : 8'hxx;
      total++;
      if (got !== ref_mem[i]) begin bad++; $display("FAIL dump_byte%0d: got %h want %h", i, got, ref_mem[i]); end
    end
    total++;
    if (n1_tx - tx1 !== 1 || n1_dd - dd1 !== 1 || t1_byte !== ref_mem[0]) begin
      bad++;
      $display("FAIL single_dump: tx=%0d done=%0d byte=%h want 1 1 %h", n1_tx - tx1, n1_dd - dd1, t1_byte, ref_mem[0]);
    end
  endtask

  task automatic test_both_starts();
    u1_en = 1'b0;
    for (int i = 0; i < 4; i++) pat[i] = 8'($urandom);
    load_image(1'b1, 1);
    u1_en = 1'b1;
  endtask

  task automatic test_unexpected();
    int we0;
    we0 = n_we;
    rx_valid = 1'b1; rx_byte = 8'hAA; tick(); rx_valid = 1'b0;
    total++;
    if ({ram_we, rx_unexpected} !== 2'b01) begin
      bad++; $display("FAIL unexp_set: we/unexp=%b want 01", {ram_we, rx_unexpected});
    end
    repeat (5) tick();
    total++;
    if (rx_unexpected !== 1'b1 || n_we !== we0) begin
      bad++; $display("FAIL unexp_sticky: unexp=%b writes=%0d want 1 0", rx_unexpected, n_we - we0);
    end
    for (int i = 0; i < 4; i++) pat[i] = 8'($urandom);
    load_image(1'b0, 2);
    total++;
    if (rx_unexpected !== 1'b0) begin bad++; $display("FAIL unexp_clear: got %b want 0", rx_unexpected); end
  endtask

  task automatic test_abort_load();
    int ld0;
    ld0 = n_ld;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'($urandom) ^ ref_mem[2] ^ 8'h01;
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1; rx_byte = pat[i]; tick(); rx_valid = 1'b0;
      ref_mem[i] = pat[i];
    end
    rx_valid = 1'b1; rx_byte = pat[2]; abort = 1'b1; tick(); rx_valid = 1'b0; abort = 1'b0;
    total++;
    if ({busy, ram_we} !== 2'b00) begin bad++; $display("FAIL abort_load: busy/we=%b want 00", {busy, ram_we}); end
    ext_addr = 8'd1; tick();
    total++;
    if (ram_addr !== 8'd1) begin bad++; $display("FAIL ext_addr_reg: got %h want 01", ram_addr); end
    tick();
    total++;
    if (ext_rdata !== ref_mem[1]) begin bad++; $display("FAIL ext_read1: got %h want %h", ext_rdata, ref_mem[1]); end
    ext_addr = 8'd2; repeat (2) tick();
    total++;
    if (ext_rdata !== ref_mem[2]) begin bad++; $display("FAIL ext_read2: got %h want %h", ext_rdata, ref_mem[2]); end
    total++;
    if (n_ld !== ld0) begin bad++; $display("FAIL abort_no_done: load_done pulses=%0d want 0", n_ld - ld0); end
  endtask

  task automatic test_abort_dump();
    int tx0, dd0, c;
    tx0 = n_tx; dd0 = n_dd; tx_lat = 10; c = 0;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    while (n_tx - tx0 < 2 && c < 200) begin tick(); c++; end
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if ({busy, tx_start} !== 2'b00) begin bad++; $display("FAIL abort_dump: busy/tx_start=%b want 00", {busy, tx_start}); end
    repeat (30) tick();
    total++;
    if (n_dd !== dd0 || n_tx - tx0 !== 2) begin
      bad++; $display("FAIL abort_dump_counts: done=%0d tx=%0d want 0 2", n_dd - dd0, n_tx - tx0);
    end
  endtask

  task automatic test_rst_mid_dump();
    int tx0, dd0, c;
    tx0 = n_tx; dd0 = n_dd; tx_lat = 10; c = 0;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    while (n_tx - tx0 < 2 && c < 200) begin tick(); c++; end
    rx_valid = 1'b1; rx_byte = 8'h5A; tick(); rx_valid = 1'b0;
    total++;
    if ({busy, rx_unexpected} !== 2'b11) begin
      bad++; $display("FAIL dump_unexp: busy/unexp=%b want 11", {busy, rx_unexpected});
    end
    rst = 1'b1; #1;
    total++;
    if ({ram_we, tx_start, load_done, dump_done, busy, rx_unexpected, tx_byte, ram_wdata, ram_addr} !== 30'd0) begin
      bad++;
      $display("FAIL rst_async: got %h want 0", {ram_we, tx_start, load_done, dump_done, busy, rx_unexpected, tx_byte, ram_wdata, ram_addr});
    end
    tick(); rst = 1'b0;
    repeat (30) tick();
    total++;
    if (n_dd !== dd0) begin bad++; $display("FAIL rst_no_done: dump_done pulses=%0d want 0", n_dd - dd0); end
    ext_addr = 8'd3; repeat (2) tick();
    total++;
    if (ext_rdata !== ref_mem[3]) begin bad++; $display("FAIL rst_ram_kept: got %h want %h", ext_rdata, ref_mem[3]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    load_image(1'b0, 0);
    dump_image(10);
    test_both_starts();
    test_unexpected();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) pat[i] = 8'($urandom);
      load_image(1'b0, int'($urandom_range(3, 0)));
      dump_image(int'($urandom_range(12, 1)));
    end
    test_abort_load();
    test_abort_dump();
    test_rst_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
